// File: rtl/pvt_sensor_pkg.sv
// Shared types and helpers for the PVT ring-oscillator scan controller.
package pvt_sensor_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StGate,
    StDone
  } state_e;

  function automatic int unsigned CH_W(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // First set bit of mask at index >= start, wrapping modulo n; 0 if mask is empty.
  function automatic int unsigned next_set_bit(input logic [15:0] mask, input int unsigned start,
                                               input int unsigned n);
    int unsigned idx;
    logic found;
    next_set_bit = 0;
    found = 1'b0;
    for (int unsigned i = 0; i < 16; i++) begin
      idx = (start + i) % n;
      if (!found && (i < n) && mask[idx[3:0]]) begin
        next_set_bit = idx;
        found = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/pvt_sensor_scan_if.sv
// Control, result and RO-macro signals of the PVT sensor scan controller.
interface pvt_sensor_scan_if #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = 10,
  parameter int unsigned DATA_W = 16
);
  localparam int unsigned ChW = pvt_sensor_pkg::CH_W(NUM_CH);

  logic              en;
  logic              mode;
  logic [ChW-1:0]    sel;
  logic [NUM_CH-1:0] ch_mask;
  logic [CNT_W-1:0]  count;
  logic [NUM_CH-1:0] ro_in;
  logic [NUM_CH-1:0] ro_en;
  logic              busy;
  logic              o_valid;
  logic [DATA_W-1:0] o_data;
  logic [ChW-1:0]    o_ch;
  logic              o_sat;

  modport master (
    output en, mode, sel, ch_mask, count, ro_in,
    input  ro_en, busy, o_valid, o_data, o_ch, o_sat
  );

  modport slave (
    input  en, mode, sel, ch_mask, count, ro_in,
    output ro_en, busy, o_valid, o_data, o_ch, o_sat
  );

endinterface

// File: rtl/pvt_ro_edge_sync.sv
// 3-flop synchroniser for one asynchronous RO output with rising-edge detect.
module pvt_ro_edge_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic ro_i,
  output logic edge_o
);

  logic [2:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[1:0], ro_i};
    end
  end

  assign edge_o = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/pvt_sensor_scan.sv
// Multi-channel RO sensor controller: settle, gated edge count, optional window averaging,
// single-shot or round-robin scan.
module pvt_sensor_scan
  import pvt_sensor_pkg::*;
#(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned CNT_W      = 10,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned AVG_LOG2   = 0,
  parameter int unsigned SETTLE_CYC = 8
) (
  input logic              clk,
  input logic              rstn,
  pvt_sensor_scan_if.slave bus_io
);

  localparam int unsigned ChW  = CH_W(NUM_CH);
  localparam int unsigned AccW = DATA_W + AVG_LOG2;
  localparam int unsigned WinW = AVG_LOG2 + 1;
  localparam int unsigned StW  = $clog2(SETTLE_CYC + 1);
  localparam int unsigned Wins = 1 << AVG_LOG2;
  localparam logic [DATA_W-1:0] CntMax = '1;

  state_e            state_q, state_d;
  logic              en_s1_q, en_s_q, en_prev_q;
  logic [ChW-1:0]    ch_q, ch_d;
  logic              mode_q, mode_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [StW-1:0]    settle_q, settle_d;
  logic [CNT_W-1:0]  gate_q, gate_d;
  logic [WinW-1:0]   win_q, win_d;
  logic [DATA_W-1:0] edge_cnt_q, edge_cnt_d;
  logic [AccW-1:0]   acc_q, acc_d;
  logic              sat_q, sat_d;
  logic              o_valid_q, o_valid_d;
  logic [DATA_W-1:0] o_data_q, o_data_d;
  logic [ChW-1:0]    o_ch_q, o_ch_d;
  logic              o_sat_q, o_sat_d;

  logic [NUM_CH-1:0] edge_vec;
  logic              edge_now, en_rise, sel_ok, scan_ok, launch;
  logic [ChW-1:0]    launch_ch, scan_first, scan_next;
  logic [DATA_W-1:0] edge_inc;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_sync
    pvt_ro_edge_sync u_sync (
      .clk_i (clk),
      .rst_ni(rstn),
      .ro_i  (bus_io.ro_in[i]),
      .edge_o(edge_vec[i])
    );
  end

  assign edge_now   = edge_vec[ch_q];
  assign en_rise    = en_s_q & ~en_prev_q;
  assign sel_ok     = 32'(bus_io.sel) < NUM_CH;
  assign scan_ok    = en_s_q & (|bus_io.ch_mask);
  assign scan_first = ChW'(next_set_bit(16'(bus_io.ch_mask), 0, NUM_CH));
  assign scan_next  = ChW'(next_set_bit(16'(bus_io.ch_mask), (32'(ch_q) + 32'd1) % NUM_CH,
                                        NUM_CH));
  assign edge_inc   = (edge_cnt_q == CntMax) ? edge_cnt_q
                                             : edge_cnt_q + {{(DATA_W-1){1'b0}}, edge_now};

  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    mode_d     = mode_q;
    count_d    = count_q;
    settle_d   = settle_q;
    gate_d     = gate_q;
    win_d      = win_q;
    edge_cnt_d = edge_cnt_q;
    acc_d      = acc_q;
    sat_d      = sat_q;
    launch     = 1'b0;
    launch_ch  = ch_q;

    unique case (state_q)
      StIdle: begin
        if (bus_io.mode) begin
          if (scan_ok) begin
            launch    = 1'b1;
            launch_ch = scan_first;
          end
        end else if (en_rise && sel_ok) begin
          launch    = 1'b1;
          launch_ch = bus_io.sel;
        end
      end
      StSettle: begin
        if (!en_s_q) begin
          state_d = StIdle;
        end else if (settle_q == StW'(SETTLE_CYC - 1)) begin
          state_d = StGate;
        end else begin
          settle_d = settle_q + StW'(1);
        end
      end
      StGate: begin
        if (!en_s_q) begin
          state_d = StIdle;
        end else begin
          sat_d = sat_q | (edge_inc == CntMax);
          if (gate_q == count_q) begin
            acc_d      = acc_q + AccW'(edge_inc);
            edge_cnt_d = '0;
            gate_d     = '0;
            if (win_q == WinW'(Wins - 1)) begin
              state_d = StDone;
            end else begin
              win_d = win_q + WinW'(1);
            end
          end else begin
            gate_d     = gate_q + CNT_W'(1);
            edge_cnt_d = edge_inc;
          end
        end
      end
      StDone: begin
        // A scan moves on to the next channel and always re-settles.
        if (mode_q && bus_io.mode && scan_ok) begin
          launch    = 1'b1;
          launch_ch = scan_next;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (launch) begin
      state_d    = StSettle;
      ch_d       = launch_ch;
      mode_d     = bus_io.mode;
      count_d    = bus_io.count;
      settle_d   = '0;
      gate_d     = '0;
      win_d      = '0;
      edge_cnt_d = '0;
      acc_d      = '0;
      sat_d      = 1'b0;
    end
  end

  always_comb begin
    o_valid_d = (state_q == StDone);
    o_data_d  = o_data_q;
    o_ch_d    = o_ch_q;
    o_sat_d   = o_sat_q;
    if (state_q == StDone) begin
      o_data_d = DATA_W'(acc_q >> AVG_LOG2);
      o_ch_d   = ch_q;
      o_sat_d  = sat_q;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= StIdle;
      en_s1_q    <= 1'b0;
      en_s_q     <= 1'b0;
      en_prev_q  <= 1'b0;
      ch_q       <= '0;
      mode_q     <= 1'b0;
      count_q    <= '0;
      settle_q   <= '0;
      gate_q     <= '0;
      win_q      <= '0;
      edge_cnt_q <= '0;
      acc_q      <= '0;
      sat_q      <= 1'b0;
      o_valid_q  <= 1'b0;
      o_data_q   <= '0;
      o_ch_q     <= '0;
      o_sat_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      en_s1_q    <= bus_io.en;
      en_s_q     <= en_s1_q;
      en_prev_q  <= en_s_q;
      ch_q       <= ch_d;
      mode_q     <= mode_d;
      count_q    <= count_d;
      settle_q   <= settle_d;
      gate_q     <= gate_d;
      win_q      <= win_d;
      edge_cnt_q <= edge_cnt_d;
      acc_q      <= acc_d;
      sat_q      <= sat_d;
      o_valid_q  <= o_valid_d;
      o_data_q   <= o_data_d;
      o_ch_q     <= o_ch_d;
      o_sat_q    <= o_sat_d;
    end
  end

  assign bus_io.ro_en   = (state_q == StSettle || state_q == StGate) ? (NUM_CH'(1) << ch_q)
                                                                     : '0;
  assign bus_io.busy    = (state_q != StIdle);
  assign bus_io.o_valid = o_valid_q;
  assign bus_io.o_data  = o_data_q;
  assign bus_io.o_ch    = o_ch_q;
  assign bus_io.o_sat   = o_sat_q;

endmodule
